// File: rtl/fp32_tile_packer.sv
// Packs NUM_INPUTS consecutive fp32 words into one flat tile for the max/min tree.
// A short final tile is padded with its last real word so max/min are unaffected.
module fp32_tile_packer #(
   parameter int NUM_INPUTS = 4,
   parameter int IDX_W      = 16,
   parameter int CNT_W      = $clog2(NUM_INPUTS + 1)
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [31:0]              s_data,
   input  logic                     s_last,
   output logic                     m_valid,
   output logic [NUM_INPUTS*32-1:0] m_data,
   output logic [CNT_W-1:0]         m_count,
   output logic                     m_last,
   output logic [IDX_W-1:0]         m_tile_idx
);

   localparam int                LANE_W    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_INPUTS - 1);

   logic [LANE_W-1:0]         cnt;
   logic [IDX_W-1:0]          tile_idx;
   logic [NUM_INPUTS*32-1:0]  pack_buf;
   logic [NUM_INPUTS*32-1:0]  tile_next;
   logic                      accept;
   logic                      close;

   assign accept = s_valid && s_ready;
   assign close  = accept && ((cnt == LAST_LANE) || s_last);

   // Lanes at or above cnt take the incoming word: that is the write on a normal
   // accept and the replica padding on a close. Lanes above cnt are rewritten later.
   always_comb begin
      tile_next = pack_buf;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         if (LANE_W'(i) >= cnt) tile_next[32*i +: 32] = s_data;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s_ready    <= 1'b0;
         cnt        <= '0;
         tile_idx   <= '0;
         pack_buf   <= '0;
         m_valid    <= 1'b0;
         m_data     <= '0;
         m_count    <= '0;
         m_last     <= 1'b0;
         m_tile_idx <= '0;
      end else begin
         s_ready <= 1'b1;
         m_valid <= close;
         if (accept) pack_buf <= tile_next;
         if (close) begin
            m_data     <= tile_next;
            m_count    <= CNT_W'(cnt) + CNT_W'(1);
            m_last     <= s_last;
            m_tile_idx <= tile_idx;
            cnt        <= '0;
            tile_idx   <= s_last ? '0 : tile_idx + IDX_W'(1);
         end else if (accept) begin
            cnt <= cnt + LANE_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_fp32_tile_packer.sv
// Two packers (4 lanes / 16-bit index, 1 lane / 2-bit index) share one input stream;
// a queue-based reference model predicts each tile and a negedge monitor checks them.
module tb_fp32_tile_packer;

   logic        clk  = 1'b0;
   logic        rstn = 1'b1;
   logic        s_valid = 1'b0;
   logic        s_last  = 1'b0;
   logic [31:0] s_data  = '0;

   logic         s_ready4, m_valid4, m_last4;
   logic [127:0] m_data4;
   logic [2:0]   m_count4;
   logic [15:0]  m_idx4;

   logic         s_ready1, m_valid1, m_last1, m_count1;
   logic [31:0]  m_data1;
   logic [1:0]   m_idx1;

   always #5 clk = ~clk;

   fp32_tile_packer #(.NUM_INPUTS(4), .IDX_W(16)) dut4 (
      .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready4), .s_data(s_data),
      .s_last(s_last), .m_valid(m_valid4), .m_data(m_data4), .m_count(m_count4),
      .m_last(m_last4), .m_tile_idx(m_idx4));

   fp32_tile_packer #(.NUM_INPUTS(1), .IDX_W(2)) dut1 (
      .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data),
      .s_last(s_last), .m_valid(m_valid1), .m_data(m_data1), .m_count(m_count1),
      .m_last(m_last1), .m_tile_idx(m_idx1));

   typedef struct {
      logic [127:0] data;
      logic [2:0]   count;
      logic         last;
      logic [15:0]  idx;
   } tile_t;

   tile_t       exp_q[2][$];
   tile_t       held[2];
   logic [31:0] pend[2][$];
   int unsigned idx_m[2];
   bit          rdy_m = 1'b0;
   int          checks = 0;
   int          errors = 0;

   function automatic void cmp(string nm, int d, logic [127:0] act, logic [127:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s dut%0d: got %h want %h", nm, d, act, want);
      end
   endfunction

   function automatic void clear_model(int d);
      pend[d].delete();
      exp_q[d].delete();
      held[d].data  = '0;
      held[d].count = '0;
      held[d].last  = 1'b0;
      held[d].idx   = '0;
      idx_m[d]      = 0;
   endfunction

   // Reference: collect words until the tile is full or the tensor ends, then pad with the last word.
   function automatic void model_accept(int d, logic [31:0] w, logic l);
      int    n = (d == 0) ? 4 : 1;
      int    modn = (d == 0) ? 65536 : 4;
      tile_t t;
      pend[d].push_back(w);
      if (pend[d].size() == n || l) begin
         t.data = '0;
         for (int i = 0; i < n; i++)
            t.data[32*i +: 32] = (i < pend[d].size()) ? pend[d][i] : w;
         t.count = 3'(pend[d].size());
         t.last  = l;
         t.idx   = 16'(idx_m[d]);
         idx_m[d] = l ? 0 : (idx_m[d] + 1) % modn;
         exp_q[d].push_back(t);
         pend[d].delete();
      end
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rdy_m = 1'b0;
         clear_model(0);
         clear_model(1);
      end else begin
         if (s_valid && rdy_m) begin
            model_accept(0, s_data, s_last);
            model_accept(1, s_data, s_last);
         end
         rdy_m = 1'b1;
      end
   end

   // A pulse is due exactly when the model closed a tile at the preceding edge.
   function automatic void monitor_dut(int d, logic mv, logic sr, logic [127:0] md,
                                       logic [2:0] mc, logic ml, logic [15:0] mi);
      bit due = (exp_q[d].size() != 0);
      cmp("m_valid", d, 128'(mv), 128'(due));
      cmp("s_ready", d, 128'(sr), 128'(rdy_m));
      if (due) held[d] = exp_q[d].pop_front();
      cmp("m_data", d, md, held[d].data);
      cmp("m_count", d, 128'(mc), 128'(held[d].count));
      cmp("m_last", d, 128'(ml), 128'(held[d].last));
      cmp("m_tile_idx", d, 128'(mi), 128'(held[d].idx));
   endfunction

   always @(negedge clk) begin
      monitor_dut(0, m_valid4, s_ready4, m_data4, m_count4, m_last4, m_idx4);
      monitor_dut(1, m_valid1, s_ready1, {96'b0, m_data1}, {2'b0, m_count1}, m_last1,
                  {14'b0, m_idx1});
   end

   task automatic idle(input int n);
      s_valid = 1'b0;
      repeat (n) begin
         s_data = $urandom;
         s_last = 1'($urandom);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [31:0] w, input logic l, input int gaps);
      idle(gaps);
      s_valid = 1'b1;
      s_data  = w;
      s_last  = l;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   function automatic logic [31:0] rand_word();
      case ($urandom_range(0, 7))
         0: return 32'h7FC00000;
         1: return 32'h80000000;
         2: return 32'h00000000;
         3: return 32'hFF800000;
         4: return 32'h7F800001;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1 rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      idle(1);

      send(32'h3F800000, 1'b0, 0);
      send(32'h40000000, 1'b0, 0);
      send(32'h40400000, 1'b0, 0);
      send(32'h40800000, 1'b1, 0);
      idle(2);

      for (int i = 0; i < 6; i++) send(32'hA0000000 + 32'(i), (i == 5), 0);
      idle(2);

      for (int i = 0; i < 12; i++) send($urandom, 1'b0, 0);
      for (int i = 0; i < 4; i++) send($urandom, (i == 3), $urandom_range(0, 3));
      idle(3);

      send(32'h11111111, 1'b0, 0);
      send(32'h22222222, 1'b0, 0);
      rstn = 1'b0;
      idle(1);
      rstn = 1'b1;
      idle(1);
      send(32'h47000000, 1'b0, 0);
      send(32'h48000000, 1'b0, 0);
      send(32'h49000000, 1'b0, 0);
      send(32'h4A000000, 1'b1, 0);
      idle(2);

      for (int i = 0; i < 8; i++) send($urandom, (i >= 6), 0);
      idle(1);

      send(32'hFF800000, 1'b1, 0);
      idle(2);

      for (int i = 0; i < 400; i++)
         send(rand_word(), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
      send(rand_word(), 1'b1, 0);
      idle(3);

      for (int d = 0; d < 2; d++) begin
         cmp("undrained_tiles", d, 128'(exp_q[d].size()), 128'(0));
         cmp("open_partial", d, 128'(pend[d].size()), 128'(0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fp32_tile_packer.md
# fp32_tile_packer

Streaming front-end for the fp32 max/min reduction tree. Accepts one 32-bit fp32 word per cycle and packs NUM_INPUTS consecutive words into a flat tile bus. Emits each tile with a one-cycle valid pulse that drives the reduction tree's input-valid directly. A partial final tile is padded with a replica of its last real element, so the padding never changes the tile's max or min.

## Interface
- NUM_INPUTS, 4: lanes per tile. Must be ≥1 and must match the downstream reduction tree.
- IDX_W, 16: width of the tile index counter.
- CNT_W, derived: clog2(NUM_INPUTS+1), the width of m_count.
- clk  in  1  single clock; all logic is rising-edge.
- rstn  in  1  reset, asynchronous and active-low.
- s_valid  in  1  input word valid.
- s_ready  out  1  packer can accept a word.
- s_data  in  32  fp32 input word.
- s_last  in  1  the accompanying word is the final element of the tensor; it closes the current tile.
- m_valid  out  1  one-cycle pulse: m_data, m_count, m_last and m_tile_idx are valid this cycle.
- m_data  out  NUM_INPUTS*32  packed tile. Lane i occupies bits [32*i+31:32*i]. Lane 0 is the first word accepted.
- m_count  out  CNT_W  number of real (unpadded) lanes, 1..NUM_INPUTS.
- m_last  out  1  this tile closes the tensor.
- m_tile_idx  out  IDX_W  index of this tile within the current tensor, starting at 0.

## Operation
- **Handshake:** a word is accepted on any rising edge where s_valid && s_ready.
- **Backpressure:** the downstream tree has none, so no backpressure path exists. s_ready is 0 while reset is asserted and 1 from the first clock edge after reset release onward.
- **Fill state:** internal pack buffer (NUM_INPUTS lanes) plus a lane counter cnt (0..NUM_INPUTS-1). An accepted word is written to lane cnt.
- **Close condition:** a tile closes when the accepted word has cnt==NUM_INPUTS-1 or s_last==1.
- **Padding on close:** lanes cnt+1..NUM_INPUTS-1 are written with the same s_data as the closing word.
- **Output load on close:** the output registers load the completed tile. m_count = cnt+1 and m_last = s_last. m_tile_idx loads the current tile counter.
- **Counter update on close:** cnt returns to 0. The tile counter then increments modulo 2^IDX_W, or clears to 0 if s_last was set.
- **Accept without close:** cnt increments and nothing is emitted.
- **Output hold:** m_data, m_count, m_last and m_tile_idx are held stable between emissions. The pack buffer is separate from the output registers, so filling the next tile never disturbs the presented tile. This holds even when the downstream tree is built without pipeline registers.
- **NUM_INPUTS==1:** every accepted word closes a tile, m_count is always 1, and no padding occurs.
- **Data content:** words are bit-exact and never interpreted. NaN and ±0 pass through untouched.
- **s_last with no accept:** ignored; s_last is sampled only when the word is accepted.
- **Reset (asynchronous, at any time including mid-tile):** cnt=0, tile counter=0, pack buffer=0, m_valid=0, m_data=0, m_count=0, m_last=0, m_tile_idx=0, s_ready=0. Any partial tile is discarded and no emission follows.

## Timing
- **Latency:** the closing word accepted at edge t produces m_valid=1 during cycle t..t+1. m_valid is registered and drops at the next edge unless another close occurs.
- **Throughput:** one word per cycle. With continuous input, m_valid pulses every NUM_INPUTS cycles.
- **Back-to-back tiles:** a word accepted in the same cycle that m_valid is high lands in lane 0 of the next tile. There is no bubble.
- **Gaps:** gaps in s_valid stall filling without timeout. A partial tile waits indefinitely for more words or s_last.
- **Downstream sampling:** the tree samples on m_valid. Its out_valid follows by the tree's pipeline depth and is not generated here.

## Test plan
- **Full tiles:** NUM_INPUTS=4; stream 0x3F800000, 0x40000000, 0x40400000, 0x40800000 with s_last on the 4th. Expect one m_valid pulse one cycle after the 4th accept, lanes in that order, m_count=4, m_last=1, m_tile_idx=0.
- **Partial tile padding:** NUM_INPUTS=4; send 6 words A..F with s_last on F. Expect tile0 = {A,B,C,D} with m_count=4, m_last=0, idx=0. Expect tile1 = {E,F,F,F} with m_count=2, m_last=1, idx=1.
- **Back-to-back with gaps:** send 12 words continuously, then 4 more with random s_valid gaps. Expect m_valid at cycles 4, 8 and 12 after the first accept, then one pulse after the 16th accept. Expect idx 0..3, and m_data held stable between pulses.
- **Reset mid-tile:** accept 2 words, assert rstn low for 1 cycle, release, then send 4 words G..J with s_last. Expect no emission from the discarded words, s_ready=0 during reset, and a single tile {G,H,I,J} with idx=0.
- **Index wrap / s_last clear:** IDX_W=2, NUM_INPUTS=1; send 6 words without s_last, then 1 with s_last, then 1 more. Expect idx 0,1,2,3,0,1,2 with m_last=1 on the 7th, then idx=0 on the 8th.
- **Single-word tensor:** NUM_INPUTS=4; send one word 0xFF800000 (-inf) with s_last. Expect m_data with all four lanes 0xFF800000, m_count=1, m_last=1.
